// File: rtl/xor_issue_arbiter.sv
`default_nettype none
// xor_issue_arbiter: two-requester round-robin XOR issue unit, fixed-latency pipeline into a
// credit-limited FWFT result FIFO. Optional response counter: XOR_ISSUE_ARB_PERF_EN. Rev 1.0
module xor_issue_arbiter #(
  parameter int DELAY_CYCLES = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int ID_W         = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [63:0]       req_rs1_i,
  input  logic [63:0]       req_rs2_i,
  input  logic [2*ID_W-1:0] req_id_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_data_o,
  output logic [ID_W-1:0]   rsp_id_o,
  output logic              rsp_src_o,
  output logic              busy_o
`ifdef XOR_ISSUE_ARB_PERF_EN
  ,
  output logic [31:0]       perf_cnt_o
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 32 + ID_W + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  logic                            rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]                   in_flight_q, in_flight_d;
  logic [CW-1:0]                   fifo_count_q, fifo_count_d;
  logic [AW-1:0]                   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                   rd_ptr_q, rd_ptr_d;
  logic [DELAY_CYCLES-1:0]         pipe_vld_q, pipe_vld_d;
  logic [DELAY_CYCLES-1:0][EW-1:0] pipe_ent_q, pipe_ent_d;
  logic [FIFO_DEPTH-1:0][EW-1:0]   mem_q, mem_d;

  logic          credit;
  logic          grant_src;
  logic          accept;
  logic          push;
  logic          pop;
  logic [EW-1:0] acc_ent;
  logic [EW-1:0] head_ent;

  // Credit looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign credit = ({1'b0, in_flight_q} + {1'b0, fifo_count_q}) < DEPTH_L;

  always_comb begin
    grant_src = req_valid_i[1];
    if (req_valid_i == 2'b11) begin
      grant_src = rr_ptr_q;
    end
  end

  always_comb begin
    req_ready_o = 2'b00;
    if (credit && !rst_i && (req_valid_i != 2'b00)) begin
      req_ready_o[grant_src] = 1'b1;
    end
  end

  assign accept   = |(req_valid_i & req_ready_o);
  assign acc_ent  = grant_src ? {req_rs1_i[63:32] ^ req_rs2_i[63:32], req_id_i[2*ID_W-1:ID_W], 1'b1}
                              : {req_rs1_i[31:0] ^ req_rs2_i[31:0], req_id_i[ID_W-1:0], 1'b0};
  assign push     = pipe_vld_q[DELAY_CYCLES-1];
  assign head_ent = mem_q[rd_ptr_q];

  assign rsp_valid_o = (fifo_count_q != '0);
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign rsp_data_o  = rsp_valid_o ? head_ent[EW-1:ID_W+1] : 32'h0;
  assign rsp_id_o    = rsp_valid_o ? head_ent[ID_W:1] : '0;
  assign rsp_src_o   = rsp_valid_o & head_ent[0];
  assign busy_o      = (in_flight_q != '0) || (fifo_count_q != '0);

  always_comb begin
    rr_ptr_d      = accept ? ~grant_src : rr_ptr_q;
    pipe_vld_d    = pipe_vld_q;
    pipe_ent_d    = pipe_ent_q;
    pipe_vld_d[0] = accept;
    pipe_ent_d[0] = acc_ent;
    for (int i = 1; i < DELAY_CYCLES; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_ent_d[i] = pipe_ent_q[i-1];
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = pipe_ent_q[DELAY_CYCLES-1];
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    fifo_count_d = fifo_count_q;
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CW'(1);
      2'b01:   fifo_count_d = fifo_count_q - CW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase

    in_flight_d = in_flight_q;
    case ({accept, push})
      2'b10:   in_flight_d = in_flight_q + CW'(1);
      2'b01:   in_flight_d = in_flight_q - CW'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q     <= 1'b0;
      in_flight_q  <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pipe_vld_q   <= '0;
      pipe_ent_q   <= '0;
      mem_q        <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      in_flight_q  <= in_flight_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_ent_q   <= pipe_ent_d;
      mem_q        <= mem_d;
    end
  end

`ifdef XOR_ISSUE_ARB_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (pop) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_cnt_q <= 32'h0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_cnt_o = perf_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xor_issue_arbiter.sv
`default_nettype none
// Randomized scoreboard bench for xor_issue_arbiter plus directed latency, backpressure and reset cases.
module tb_xor_issue_arbiter;
  localparam int D     = 1;
  localparam int D3    = 3;
  localparam int DEPTH = 4;
  localparam int IDW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_ready;
  logic [63:0]      rs1, rs2;
  logic [2*IDW-1:0] ids;
  logic             rsp_valid, rsp_ready, rsp_src, busy;
  logic [31:0]      rsp_data;
  logic [IDW-1:0]   rsp_id;

  logic [1:0]       v3, ready3;
  logic [63:0]      rs1_3, rs2_3;
  logic [2*IDW-1:0] ids3;
  logic             valid3, rsp_ready3, src3, busy3;
  logic [31:0]      data3;
  logic [IDW-1:0]   id3;
`ifdef XOR_ISSUE_ARB_PERF_EN
  logic [31:0]      perf, perf3;
`endif

  xor_issue_arbiter #(.DELAY_CYCLES(D), .FIFO_DEPTH(DEPTH), .ID_W(IDW)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_rs1_i(rs1), .req_rs2_i(rs2), .req_id_i(ids), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_id_o(rsp_id),
    .rsp_src_o(rsp_src), .busy_o(busy)
`ifdef XOR_ISSUE_ARB_PERF_EN
    , .perf_cnt_o(perf)
`endif
  );

  xor_issue_arbiter #(.DELAY_CYCLES(D3), .FIFO_DEPTH(DEPTH), .ID_W(IDW)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v3), .req_ready_o(ready3),
    .req_rs1_i(rs1_3), .req_rs2_i(rs2_3), .req_id_i(ids3), .rsp_valid_o(valid3),
    .rsp_ready_i(rsp_ready3), .rsp_data_o(data3), .rsp_id_o(id3),
    .rsp_src_o(src3), .busy_o(busy3)
`ifdef XOR_ISSUE_ARB_PERF_EN
    , .perf_cnt_o(perf3)
`endif
  );

  typedef struct {
    logic [31:0]    data;
    logic [IDW-1:0] id;
    logic           src;
    int             acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        ptr_m = 1'b0;
  logic [31:0] hs_m = 32'h0;
  logic [1:0]  m_exp_rdy;
  logic        m_k;
  logic        hold_m = 1'b0;
  logic [31:0] hold_d;
  logic [IDW-1:0] hold_id;
  logic        hold_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: outstanding work is simply accepted-minus-responded; a result becomes
  // visible D+1 cycles after its handshake cycle and leaves in acceptance order.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_src", rsp_src, 0);
      chk("rst_busy", busy, 0);
      sb.delete();
      ptr_m  = 1'b0;
      hs_m   = 32'h0;
      hold_m = 1'b0;
    end else begin
      m_exp_rdy = 2'b00;
      if (sb.size() < DEPTH && req_valid != 2'b00) begin
        if (req_valid == 2'b11) m_exp_rdy = ptr_m ? 2'b10 : 2'b01;
        else m_exp_rdy = req_valid;
      end
      chk("req_ready", req_ready, m_exp_rdy);
      chk("busy", busy, sb.size() != 0);
      chk("rsp_valid", rsp_valid, (sb.size() != 0) && (cyc >= sb[0].acc + D + 1));
`ifdef XOR_ISSUE_ARB_PERF_EN
      chk("perf_cnt", perf, hs_m);
`endif
      if (hold_m) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_data", rsp_data, hold_d);
        chk("hold_id", rsp_id, hold_id);
        chk("hold_src", rsp_src, hold_s);
      end
      hold_m  = rsp_valid && !rsp_ready;
      hold_d  = rsp_data;
      hold_id = rsp_id;
      hold_s  = rsp_src;
      if (rsp_valid && rsp_ready) begin
        hs_m = hs_m + 32'd1;
        if (sb.size() != 0) begin
          m_e = sb.pop_front();
          chk("rsp_data", rsp_data, m_e.data);
          chk("rsp_id", rsp_id, m_e.id);
          chk("rsp_src", rsp_src, m_e.src);
        end
      end
      if ((req_valid & req_ready) != 2'b00) begin
        m_k      = req_ready[1];
        m_e.src  = m_k;
        m_e.data = m_k ? (rs1[63:32] ^ rs2[63:32]) : (rs1[31:0] ^ rs2[31:0]);
        m_e.id   = m_k ? ids[2*IDW-1:IDW] : ids[IDW-1:0];
        m_e.acc  = cyc;
        sb.push_back(m_e);
        ptr_m = ~m_k;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    rs1 = {$urandom(), $urandom()};
    rs2 = {$urandom(), $urandom()};
    ids = (2*IDW)'($urandom());
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      if (!busy && !busy3) break;
      tick();
    end
    @(negedge clk);
    chk(name, {busy, busy3}, 2'b00);
    tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_acc;
    req_valid = 2'b00; rs1 = '0; rs2 = '0; ids = '0; rsp_ready = 1'b1;
    v3 = 2'b00; rs1_3 = {32'h0, 32'h12345678}; rs2_3 = {32'h0, 32'h00FF00FF};
    ids3 = (2*IDW)'(2); rsp_ready3 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single op from requester 0, minimum latency.
    req_valid = 2'b01; rs1[31:0] = 32'hFFFF0000; rs2[31:0] = 32'h0F0F0F0F; ids[IDW-1:0] = 3'd5;
    @(negedge clk); chk("t1_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    @(negedge clk); chk("t1_valid_early", rsp_valid, 0);
    @(negedge clk);
    chk("t1_valid", rsp_valid, 1);
    chk("t1_data", rsp_data, 32'hF0F00F0F);
    chk("t1_id", rsp_id, 5);
    chk("t1_src", rsp_src, 0);
    wait_idle("t1_idle");

    // Both requesters valid after reset alternate 0,1,0,1.
    pulse_rst();
    req_valid = 2'b11; rand_ops();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t2_grant", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick(); rand_ops();
    end
    req_valid = 2'b00;
    wait_idle("t2_idle");

    // Backpressure fills exactly FIFO_DEPTH, then a pop frees credit only a cycle later.
    rsp_ready = 1'b0; req_valid = 2'b01; rand_ops(); n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); if ((req_valid & req_ready) != 2'b00) n_acc++;
      tick(); rand_ops();
    end
    chk("t3_accepts", n_acc, DEPTH);
    @(negedge clk); chk("t3_ready_full", req_ready, 2'b00); chk("t3_busy", busy, 1);
    tick(); rsp_ready = 1'b1;
    @(negedge clk); chk("t4_no_accept_on_pop", req_ready, 2'b00); chk("t4_pop", rsp_valid, 1);
    tick(); rand_ops();
    @(negedge clk); chk("t4_accept_next", req_ready, 2'b01);
    tick();
    repeat (5) begin rand_ops(); tick(); end
    req_valid = 2'b00;
    wait_idle("t4_idle");

    // Random traffic and backpressure.
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom());
      rsp_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      tick();
    end
    req_valid = 2'b00; rsp_ready = 1'b1;
    wait_idle("rand_idle");

    // Deeper pipeline: latency, then reset with three operations in flight.
    v3 = 2'b01;
    @(negedge clk); chk("d3_ready", ready3, 2'b01);
    tick(); v3 = 2'b00;
    for (int i = 1; i <= D3 + 1; i++) begin
      @(negedge clk); chk("d3_latency", valid3, i == D3 + 1);
    end
    chk("d3_data", data3, 32'h12CB5687);
    chk("d3_id", id3, 2);
    chk("d3_src", src3, 0);
    tick();
    rsp_ready3 = 1'b0; v3 = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("d3_fill", ready3, 2'b01);
      tick();
    end
    v3 = 2'b00;
    chk("d3_busy_pre", busy3, 1);
    rst = 1'b1;
    #1;
    chk("d3_rst_ready", ready3, 0);
    chk("d3_rst_valid", valid3, 0);
    chk("d3_rst_data", data3, 0);
    chk("d3_rst_id", id3, 0);
    chk("d3_rst_src", src3, 0);
    chk("d3_rst_busy", busy3, 0);
`ifdef XOR_ISSUE_ARB_PERF_EN
    chk("d3_rst_perf", perf3, 0);
`endif
    @(negedge clk);
    tick(); rst = 1'b0; rsp_ready3 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("d3_no_rsp", valid3, 0);
      chk("d3_no_busy", busy3, 0);
    end
    tick();

`ifdef XOR_ISSUE_ARB_PERF_EN
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_valid = 2'b01; rand_ops(); tick();
    end
    req_valid = 2'b00;
    wait_idle("perf_idle");
    @(negedge clk); chk("perf_10", perf, 10);
    tick();
    force dut.perf_cnt_q = 32'hFFFFFFFF;
    #1 release dut.perf_cnt_q;
    hs_m = 32'hFFFFFFFF;
    req_valid = 2'b01; rand_ops(); tick(); req_valid = 2'b00;
    wait_idle("perf_wrap_idle");
    @(negedge clk); chk("perf_wrap", perf, 0);
    tick();
`endif

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
